// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow finish at once.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [1:0]      DivOp,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] Result
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            isrem_q, isrem_d;

   logic            sgn, a_neg, b_neg, ovf, ge;
   logic [XLEN-1:0] a_abs, b_abs;
   logic [XLEN:0]   r_sh, diff;
   logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

   always_comb begin
      sgn   = ~DivOp[0];
      a_neg = sgn & A[XLEN-1];
      b_neg = sgn & B[XLEN-1];
      a_abs = a_neg ? -A : A;
      b_abs = b_neg ? -B : B;
      ovf   = sgn & (A == MIN_NEG) & (&B);

      // quo_q shifts the dividend out while quotient bits shift in
      r_sh   = {rem_q, quo_q[XLEN-1]};
      diff   = r_sh - {1'b0, dvs_q};
      ge     = ~diff[XLEN];
      rem_nx = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], ge};
      q_fix  = qneg_q ? -quo_nx : quo_nx;
      r_fix  = rneg_q ? -rem_nx : rem_nx;

      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      isrem_d = isrem_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               isrem_d = DivOp[1];
               if (B == '0) begin
                  res_d   = DivOp[1] ? A : '1;
                  state_d = DONE;
               end else if (ovf) begin
                  res_d   = DivOp[1] ? '0 : A;
                  state_d = DONE;
               end else begin
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_abs;
                  dvs_d   = b_abs;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               res_d   = isrem_q ? r_fix : q_fix;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         isrem_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         isrem_q <= isrem_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign Result    = res_q;

endmodule
